seq_detect_param: RTL

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_detect_param.sv | 94 +++++++++
 1 files changed

// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector.
// Takes a serial bit stream. Gives a combinational match flag, the same
// flag registered one cycle later, and a saturating count of matches.
// The pattern register is loadable at run time. Matching can be
// overlapping or non-overlapping.
module seq_detect_param #(
   parameter int             LEN     = 4,
   parameter logic [LEN-1:0] PATTERN = 4'b1101,
   parameter int             CNT_W   = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             datain,
   input  logic             datain_valid,
   input  logic             overlap,
   input  logic             pattern_load,
   input  logic [LEN-1:0]   pattern_in,
   input  logic             count_clear,
   output logic             dataout,
   output logic             dataout_q,
   output logic [CNT_W-1:0] match_count
);

   // fill only needs to reach LEN-1, so clog2(LEN) bits are enough
   localparam int               FW       = $clog2(LEN);
   localparam logic [FW-1:0]    FILL_MAX = FW'(LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [LEN-2:0]   hist_q, hist_d;
   logic [FW-1:0]    fill_q, fill_d;
   logic [LEN-1:0]   pat_q, pat_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [LEN-1:0]   window;
   logic             match;

   // candidate window: stored history with the incoming bit appended as the newest (LSB)
   assign window = {hist_q, datain};

   // Mealy match: valid bit, history fully populated, window equals pattern, no load this cycle
   always_comb begin
      match = datain_valid && !pattern_load && (fill_q == FILL_MAX) && (window == pat_q);
   end

   assign dataout     = match;
   assign match_count = cnt_q;

   // next-state for history, fill level and pattern register
   always_comb begin
      hist_d = hist_q;
      fill_d = fill_q;
      pat_d  = pat_q;
      if (pattern_load) begin
         // a load restarts detection; the data bit in this cycle is dropped
         pat_d  = pattern_in;
         fill_d = '0;
      end else if (datain_valid) begin
         hist_d = window[LEN-2:0];
         if (match && !overlap) begin
            // non-overlapping: the matching bits are consumed and not reused
            fill_d = '0;
         end else if (fill_q != FILL_MAX) begin
            fill_d = fill_q + 1'b1;
         end
      end
   end

   // saturating match counter; clear takes priority over increment
   always_comb begin
      cnt_d = cnt_q;
      if (count_clear) begin
         cnt_d = '0;
      end else if (match && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // state registers with asynchronous active-low reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hist_q    <= '0;
         fill_q    <= '0;
         pat_q     <= PATTERN;
         cnt_q     <= '0;
         dataout_q <= 1'b0;
      end else begin
         hist_q    <= hist_d;
         fill_q    <= fill_d;
         pat_q     <= pat_d;
         cnt_q     <= cnt_d;
         dataout_q <= match;
      end
   end

endmodule
